// File: rtl/dp_seq_scheduler_pkg.sv
// Shared constants for the DP job sequencer: default array geometry,
// drain length and the 3-bit scheduler state encoding.
package dp_seq_scheduler_pkg;

  localparam int DEF_BP_WIDTH     = 2;
  localparam int DEF_N            = 32;
  localparam int DEF_LOG_N        = 5;
  localparam int DEF_T_LEN_W      = 12;
  localparam int DEF_DRAIN_CYCLES = DEF_N;

  typedef enum logic [2:0] {
    SCH_IDLE     = 3'd0,
    SCH_LOAD_S   = 3'd1,
    SCH_STREAM_T = 3'd2,
    SCH_DRAIN    = 3'd3,
    SCH_ACK      = 3'd4,
    SCH_SWAP     = 3'd5
  } sch_state_t;

endpackage

// File: rtl/dp_seq_scheduler_beat_counter.sv
// Load/enable counter with terminal-count flag; tc compares the value being
// registered this cycle, so it flags the beat that reaches term. DOWN saturates at 0.
module dp_seq_scheduler_beat_counter #(
  parameter int W    = 4,
  parameter bit DOWN = 1'b0
) (
  input  logic         clk,
  input  logic         reset_i,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt_q;
    if (clr) begin
      cnt_nxt = '0;
    end else if (load) begin
      cnt_nxt = load_val;
    end else if (en) begin
      if (DOWN) begin
        if (cnt_q != '0) cnt_nxt = cnt_q - ONE;
      end else begin
        if (cnt_q != '1) cnt_nxt = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) cnt_q <= '0;
    else          cnt_q <= cnt_nxt;
  end

  assign tc = (cnt_nxt == term);

endmodule

// File: rtl/dp_seq_scheduler.sv
// Sequences one alignment job into the DP array: load S, stream T, drain, ack, swap.
// Strobes/data lag a stream beat by 1 cycle; t_ready drops combinationally with dp_busy.
module dp_seq_scheduler
  import dp_seq_scheduler_pkg::*;
#(
  parameter int BP_WIDTH     = DEF_BP_WIDTH,
  parameter int N            = DEF_N,
  parameter int LOG_N        = DEF_LOG_N,
  parameter int T_LEN_W      = DEF_T_LEN_W,
  parameter int DRAIN_CYCLES = N
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                abort,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [LOG_N:0]      s_len,
  input  logic [T_LEN_W-1:0]  t_len,
  input  logic [BP_WIDTH-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [BP_WIDTH-1:0] t_data,
  input  logic                t_valid,
  output logic                t_ready,
  output logic [BP_WIDTH-1:0] dp_S,
  output logic                dp_s_update,
  output logic [BP_WIDTH-1:0] dp_T,
  output logic                dp_valid,
  output logic [LOG_N-1:0]    dp_PE_end,
  output logic                dp_new_seq,
  output logic                dp_ack,
  input  logic                dp_busy,
  input  logic                tb_busy,
  output logic                job_done,
  output logic                job_err,
  output logic [15:0]         job_cnt
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [LOG_N:0] S_MAX = (LOG_N+1)'(N);
  localparam logic [LOG_N:0] S_ONE = (LOG_N+1)'(1);

  sch_state_t           state_q;
  sch_state_t           state_nxt;
  logic [LOG_N:0]       s_len_q;
  logic [T_LEN_W-1:0]   t_len_q;
  logic job_hs, job_bad, s_beat, t_beat, s_last, t_last;
  logic drain_tc, drain_exit, swap_fire, in_idle;

  assign in_idle    = (state_q == SCH_IDLE);
  assign job_hs     = job_valid & job_ready;
  assign job_bad    = (s_len == '0) | (s_len > S_MAX) | (t_len == '0);
  assign s_beat     = s_valid & s_ready;
  assign t_beat     = t_valid & t_ready;
  assign drain_exit = (state_q == SCH_DRAIN) & drain_tc & ~dp_busy & ~abort;
  // tb_busy is sampled here, so dp_new_seq (registered) only follows an idle traceback
  assign swap_fire  = (state_q == SCH_SWAP) & ~tb_busy & ~abort;

  dp_seq_scheduler_beat_counter #(.W(LOG_N+1), .DOWN(1'b0)) u_s_cnt (
    .clk(clk), .reset_i(reset_i), .clr(abort | in_idle), .load(1'b0), .load_val('0),
    .en(s_beat), .term(s_len_q), .tc(s_last)
  );

  dp_seq_scheduler_beat_counter #(.W(T_LEN_W), .DOWN(1'b0)) u_t_cnt (
    .clk(clk), .reset_i(reset_i), .clr(abort | in_idle), .load(1'b0), .load_val('0),
    .en(t_beat), .term(t_len_q), .tc(t_last)
  );

  dp_seq_scheduler_beat_counter #(.W(DRAIN_W), .DOWN(1'b1)) u_drain_cnt (
    .clk(clk), .reset_i(reset_i), .clr(abort), .load(t_beat & t_last),
    .load_val(DRAIN_W'(DRAIN_CYCLES)), .en(state_q == SCH_DRAIN), .term('0), .tc(drain_tc)
  );

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) state_q <= SCH_IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (abort) begin
      state_nxt = SCH_IDLE;
    end else begin
      case (state_q)
        SCH_IDLE:     if (job_hs && !job_bad)   state_nxt = SCH_LOAD_S;
        SCH_LOAD_S:   if (s_beat && s_last)     state_nxt = SCH_STREAM_T;
        SCH_STREAM_T: if (t_beat && t_last)     state_nxt = SCH_DRAIN;
        SCH_DRAIN:    if (drain_exit)           state_nxt = SCH_ACK;
        SCH_ACK:                                state_nxt = SCH_SWAP;
        SCH_SWAP:     if (swap_fire)            state_nxt = SCH_IDLE;
        default:                                state_nxt = SCH_IDLE;
      endcase
    end
  end

  // Readies also drop on abort so a beat is never accepted and then discarded
  always_comb begin
    job_ready = 1'b0;
    s_ready   = 1'b0;
    t_ready   = 1'b0;
    case (state_q)
      SCH_IDLE:     job_ready = ~abort;
      SCH_LOAD_S:   s_ready   = ~abort;
      SCH_STREAM_T: t_ready   = ~abort & ~dp_busy;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      dp_S        <= '0;
      dp_T        <= '0;
      dp_s_update <= 1'b0;
      dp_valid    <= 1'b0;
      dp_ack      <= 1'b0;
      dp_new_seq  <= 1'b0;
      dp_PE_end   <= '0;
      job_done    <= 1'b0;
      job_err     <= 1'b0;
      job_cnt     <= '0;
      s_len_q     <= '0;
      t_len_q     <= '0;
    end else begin
      dp_s_update <= s_beat;
      dp_valid    <= t_beat;
      dp_ack      <= drain_exit;
      dp_new_seq  <= swap_fire;
      job_done    <= swap_fire;
      job_err     <= job_hs & job_bad;
      if (s_beat)    dp_S    <= s_data;
      if (t_beat)    dp_T    <= t_data;
      if (swap_fire) job_cnt <= job_cnt + 16'd1;
      if (job_hs && !job_bad) begin
        s_len_q   <= s_len;
        t_len_q   <= t_len;
        dp_PE_end <= LOG_N'(s_len - S_ONE);
      end
    end
  end

endmodule

// File: tb/tb_dp_seq_scheduler.sv
// Directed bench for dp_seq_scheduler: table of jobs plus abort and reset sequences.
module tb_dp_seq_scheduler;

  localparam int BPW = 2, N = 32, LOG_N = 5, TLW = 12, DRN = 32;

  logic clk = 1'b0, reset_i = 1'b0, abort = 1'b0, job_valid = 1'b0;
  logic [LOG_N:0] s_len = '0;
  logic [TLW-1:0] t_len = '0;
  logic [BPW-1:0] s_data = '0, t_data = '0;
  logic s_valid = 1'b0, t_valid = 1'b0, dp_busy = 1'b0, tb_busy = 1'b0;
  logic job_ready, s_ready, t_ready, dp_s_update, dp_valid, dp_new_seq, dp_ack, job_done, job_err;
  logic [BPW-1:0] dp_S, dp_T;
  logic [LOG_N-1:0] dp_PE_end;
  logic [15:0] job_cnt;

  dp_seq_scheduler #(.BP_WIDTH(BPW), .N(N), .LOG_N(LOG_N), .T_LEN_W(TLW), .DRAIN_CYCLES(DRN)) dut (
    .clk(clk), .reset_i(reset_i), .abort(abort), .job_valid(job_valid), .job_ready(job_ready),
    .s_len(s_len), .t_len(t_len), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .t_data(t_data), .t_valid(t_valid), .t_ready(t_ready), .dp_S(dp_S), .dp_s_update(dp_s_update),
    .dp_T(dp_T), .dp_valid(dp_valid), .dp_PE_end(dp_PE_end), .dp_new_seq(dp_new_seq),
    .dp_ack(dp_ack), .dp_busy(dp_busy), .tb_busy(tb_busy), .job_done(job_done),
    .job_err(job_err), .job_cnt(job_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s_len; int t_len; bit err; int pe_end;
    int busy_after; int busy_len; int tb_hold;
    int exp_ack; int exp_new; int exp_cnt;
  } vec_t;

  vec_t tbl[8];
  int total = 0, bad = 0;
  int jc, s_idx, t_idx, s_seen, t_seen;
  int n_supd, n_valid, n_ack, n_new, n_done, n_err, busy_leak;
  int ack_cyc, new_cyc, err_cyc;
  logic tb_prev;
  logic [BPW-1:0] s_mem [64];
  logic [BPW-1:0] t_mem [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    jc = 1; s_idx = 0; t_idx = 0; s_seen = 0; t_seen = 0;
    n_supd = 0; n_valid = 0; n_ack = 0; n_new = 0; n_done = 0; n_err = 0; busy_leak = 0;
    ack_cyc = -1; new_cyc = -1; err_cyc = -1;
    s_data = s_mem[0]; t_data = t_mem[0];
  endtask

  // One clock: handshakes sampled at negedge, outputs observed 1 time unit after posedge
  task automatic tick();
    logic sb, tbt;
    @(negedge clk);
    sb = s_valid & s_ready;
    tbt = t_valid & t_ready;
    tb_prev = tb_busy;
    if (dp_busy && t_ready) busy_leak++;
    @(posedge clk); #1;
    jc++;
    if (sb) s_idx++;
    if (tbt) t_idx++;
    s_data = s_mem[s_idx];
    t_data = t_mem[t_idx];
    if (dp_s_update) begin n_supd++; check("s_order", dp_S, s_mem[s_seen]); s_seen++; end
    if (dp_valid) begin n_valid++; check("t_order", dp_T, t_mem[t_seen]); t_seen++; end
    if (dp_ack) begin n_ack++; ack_cyc = jc; check("ack_new_overlap", dp_new_seq, 0); end
    if (dp_new_seq) begin n_new++; new_cyc = jc; check("new_seq_tb_idle", tb_prev, 0); end
    if (job_done) n_done++;
    if (job_err) begin n_err++; err_cyc = jc; end
  endtask

  task automatic run_vec(input vec_t v);
    int budget, busy_start;
    clear_counts();
    busy_start = -1;
    s_len = (LOG_N+1)'(v.s_len);
    t_len = TLW'(v.t_len);
    tb_busy = (v.tb_hold > 0);
    check("job_ready_idle", job_ready, 1);
    job_valid = 1'b1; s_valid = 1'b1; t_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    if (v.err) begin
      repeat (4) tick();
    end else begin
      budget = 400;
      while (n_done == 0 && budget > 0) begin
        if (v.busy_len > 0 && busy_start < 0 && t_idx == v.busy_after) busy_start = jc;
        dp_busy = (busy_start >= 0) && (jc < busy_start + v.busy_len);
        tb_busy = (v.tb_hold > 0) && ((n_ack == 0) || (jc <= ack_cyc + v.tb_hold));
        tick();
        budget--;
      end
      dp_busy = 1'b0; tb_busy = 1'b0;
      repeat (2) tick();
    end
    s_valid = 1'b0; t_valid = 1'b0;
    check("err_pulses", n_err, v.err ? 1 : 0);
    check("s_updates", n_supd, v.err ? 0 : v.s_len);
    check("t_valids", n_valid, v.err ? 0 : v.t_len);
    check("acks", n_ack, v.err ? 0 : 1);
    check("new_seqs", n_new, v.err ? 0 : 1);
    check("job_dones", n_done, v.err ? 0 : 1);
    check("pe_end", dp_PE_end, v.pe_end);
    check("job_cnt", job_cnt, v.exp_cnt);
    check("job_ready_after", job_ready, 1);
    if (v.err) begin
      check("err_cycle", err_cyc, 2);
    end else begin
      check("ack_cycle", ack_cyc, v.exp_ack);
      check("new_seq_cycle", new_cyc, v.exp_new);
    end
    if (v.busy_len > 0) check("t_ready_while_busy", busy_leak, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t follow;
    for (int i = 0; i < 64; i++) begin
      s_mem[i] = BPW'(i * 3 + 1);
      t_mem[i] = BPW'(i + 2);
    end
    //            s   t  err pe bAft bLen tbH ack new cnt
    tbl[0] = '{   4,  8, 0,  3,  0,   0,  0,  46, 48, 1};
    tbl[1] = '{   0,  5, 1,  3,  0,   0,  0,   0,  0, 1};
    tbl[2] = '{  33,  5, 1,  3,  0,   0,  0,   0,  0, 1};
    tbl[3] = '{   4,  0, 1,  3,  0,   0,  0,   0,  0, 1};
    tbl[4] = '{   1,  1, 0,  0,  0,   0,  0,  36, 38, 2};
    tbl[5] = '{  32,  3, 0, 31,  0,   0,  0,  69, 71, 3};
    tbl[6] = '{   2, 16, 0,  1,  5,   5,  0,  57, 59, 4};
    tbl[7] = '{   1,  1, 0,  0,  0,   0, 20,  36, 58, 5};

    repeat (2) @(posedge clk);
    #1;
    check("rst_job_ready", job_ready, 1);
    check("rst_strobes", {dp_S, dp_T, dp_s_update, dp_valid, dp_ack, dp_new_seq, job_done, job_err}, 0);
    check("rst_pe_end", dp_PE_end, 0);
    check("rst_job_cnt", job_cnt, 0);
    reset_i = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Abort after 3 of 10 T beats
    clear_counts();
    s_len = 6'd3; t_len = 12'd10;
    job_valid = 1'b1; s_valid = 1'b1; t_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    for (int b = 0; b < 40 && t_idx < 3; b++) tick();
    check("abort_t_beats", t_idx, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    #2;
    check("abort_idle", job_ready, 1);
    check("abort_valid_low", dp_valid, 0);
    s_valid = 1'b0; t_valid = 1'b0;
    repeat (60) tick();
    check("abort_t_valids", n_valid, 3);
    check("abort_acks", n_ack, 0);
    check("abort_new_seqs", n_new, 0);
    check("abort_job_dones", n_done, 0);
    check("abort_job_cnt", job_cnt, 5);
    follow = '{4, 8, 0, 3, 0, 0, 0, 46, 48, 6};
    run_vec(follow);

    // Asynchronous reset while in DRAIN
    clear_counts();
    s_len = 6'd2; t_len = 12'd2;
    job_valid = 1'b1; s_valid = 1'b1; t_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    while (jc < 10) tick();
    check("pre_reset_pe_end", dp_PE_end, 1);
    #2;
    reset_i = 1'b0;
    #1;
    check("mid_rst_strobes", {dp_S, dp_T, dp_s_update, dp_valid, dp_ack, dp_new_seq, job_done, job_err}, 0);
    check("mid_rst_pe_end", dp_PE_end, 0);
    check("mid_rst_job_cnt", job_cnt, 0);
    check("mid_rst_readies", {s_ready, t_ready}, 0);
    @(posedge clk); #1;
    s_valid = 1'b0; t_valid = 1'b0;
    reset_i = 1'b1;
    #2;
    check("post_rst_job_ready", job_ready, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
